// File: rtl/uart_bus_pkg.sv
// Shared command codes, bus request payload and FSM state type for the UART host bus master.
package uart_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] CMD_HALT    = 8'h00;
  localparam logic [DATA_W-1:0] CMD_RESUME  = 8'h01;
  localparam logic [DATA_W-1:0] CMD_WRITE   = 8'h02;
  localparam logic [DATA_W-1:0] CMD_READ    = 8'h03;
  localparam logic [DATA_W-1:0] CMD_STATUS  = 8'h04;
  localparam logic [DATA_W-1:0] RD_ERR_BYTE = 8'hEE;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              re;
  } bus_req_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_RD_WAIT,
    ST_TX_SEND,
    ST_TX_WAIT
  } state_t;

endpackage

// File: rtl/bus_owner_mux.sv
// Selects which master drives the memory bus; the unselected master's strobes never reach the bus.
module bus_owner_mux
  import uart_bus_pkg::*;
(
  input  logic     host_own,
  input  bus_req_t cpu_req,
  input  bus_req_t host_req,
  output bus_req_t bus_req_c
);

  assign bus_req_c = host_own ? host_req : cpu_req;

endmodule

// File: rtl/uart_bus_master_ctrl.sv
// Host debug controller: parses UART commands, halts the CPU and runs single-byte bus ops.
// Build option: define UART_BUS_STATUS_CMD_EN to enable the 0x04 status-readback command.
module uart_bus_master_ctrl
  import uart_bus_pkg::*;
#(
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned BYTE_TIMEOUT = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_active,
  input  logic              tx_done,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic              bus_re,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              cpu_halt,
  output logic              host_own
);

  localparam int unsigned TO_W  = (BYTE_TIMEOUT > 2) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam int unsigned LAT_W = 3;

  state_t            st, st_d;
  logic              cpu_halt_d, host_own_d, resume_pend, resume_pend_d;
  logic              tx_start_d, is_rd, is_rd_d;
  logic [DATA_W-1:0] tx_data_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
  bus_req_t          host_req, host_req_d, cpu_req, bus_req_c;
  logic              idle_byte;

  assign cpu_req = '{addr: cpu_addr, wdata: cpu_wdata, we: cpu_we, re: cpu_re};

  bus_owner_mux u_mux (
    .host_own  (host_own),
    .cpu_req   (cpu_req),
    .host_req  (host_req),
    .bus_req_c (bus_req_c)
  );

  assign bus_addr  = bus_req_c.addr;
  assign bus_wdata = bus_req_c.wdata;
  assign bus_we    = bus_req_c.we;
  assign bus_re    = bus_req_c.re;

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= ST_IDLE;
      cpu_halt    <= 1'b0;
      host_own    <= 1'b0;
      resume_pend <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      host_req    <= '0;
      to_cnt      <= '0;
      lat_cnt     <= '0;
      is_rd       <= 1'b0;
    end else begin
      st          <= st_d;
      cpu_halt    <= cpu_halt_d;
      host_own    <= host_own_d;
      resume_pend <= resume_pend_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      host_req    <= host_req_d;
      to_cnt      <= to_cnt_d;
      lat_cnt     <= lat_cnt_d;
      is_rd       <= is_rd_d;
    end
  end

  always_comb begin
    st_d          = st;
    cpu_halt_d    = cpu_halt;
    host_own_d    = host_own;
    resume_pend_d = resume_pend;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data;
    host_req_d    = host_req;
    host_req_d.we = 1'b0;
    host_req_d.re = 1'b0;
    to_cnt_d      = '0;
    lat_cnt_d     = lat_cnt;
    is_rd_d       = is_rd;
    idle_byte     = (st == ST_IDLE) && rx_valid;

    // Halt raises cpu_halt before taking the bus; resume drops the bus before releasing the CPU.
    if (idle_byte && rx_data == CMD_HALT) begin
      cpu_halt_d    = 1'b1;
      resume_pend_d = 1'b0;
    end else if (idle_byte && rx_data == CMD_RESUME) begin
      host_own_d    = 1'b0;
      resume_pend_d = cpu_halt;
    end else if (resume_pend) begin
      cpu_halt_d    = 1'b0;
      resume_pend_d = 1'b0;
    end else if (cpu_halt) begin
      host_own_d = 1'b1;
    end

    case (st)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_WRITE: begin
              is_rd_d = 1'b0;
              st_d    = ST_ADDR_HI;
            end
            CMD_READ: begin
              is_rd_d = 1'b1;
              st_d    = ST_ADDR_HI;
            end
`ifdef UART_BUS_STATUS_CMD_EN
            CMD_STATUS: begin
              tx_data_d = {6'b0, host_own, cpu_halt};
              st_d      = ST_TX_SEND;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_ADDR_HI: begin
        if (rx_valid) begin
          host_req_d.addr[15:8] = rx_data;
          st_d                  = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (rx_valid) begin
          host_req_d.addr[7:0] = rx_data;
          if (is_rd) begin
            host_req_d.re = host_own;
            st_d          = ST_BUS_RD;
          end else begin
            st_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          host_req_d.wdata = rx_data;
          host_req_d.we    = host_own;
          st_d             = ST_BUS_WR;
        end
      end
      ST_BUS_WR: st_d = ST_IDLE;
      ST_BUS_RD: begin
        // A read issued without bus ownership never strobes and reports the error byte.
        if (host_req.re) begin
          lat_cnt_d = '0;
          st_d      = ST_RD_WAIT;
        end else begin
          tx_data_d = RD_ERR_BYTE;
          st_d      = ST_TX_SEND;
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt == LAT_W'(READ_LAT - 1)) begin
          tx_data_d = bus_rdata;
          st_d      = ST_TX_SEND;
        end else begin
          lat_cnt_d = lat_cnt + 1'b1;
        end
      end
      ST_TX_SEND: begin
        if (!tx_active) begin
          tx_start_d = 1'b1;
          st_d       = ST_TX_WAIT;
        end
      end
      ST_TX_WAIT: begin
        if (tx_done) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase

    // Inter-byte timeout while a command is partially received.
    if ((st == ST_ADDR_HI || st == ST_ADDR_LO || st == ST_DATA) && !rx_valid) begin
      if (to_cnt == TO_W'(BYTE_TIMEOUT - 1)) begin
        st_d = ST_IDLE;
      end else begin
        to_cnt_d = to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_master_ctrl.sv
// Scoreboard bench for uart_bus_master_ctrl with a latency-accurate memory model and a TX model.
module tb_uart_bus_master_ctrl;

  localparam int unsigned TB_LAT = 2;
  localparam int unsigned TB_TO  = 64;

  logic        clk = 1'b0;
  logic        rst, rx_valid, tx_start, tx_active, tx_done;
  logic [7:0]  rx_data, tx_data, cpu_wdata, bus_wdata, bus_rdata;
  logic [15:0] cpu_addr, bus_addr;
  logic        cpu_we, cpu_re, bus_we, bus_re, cpu_halt, host_own;

  logic        tx_busy = 1'b0, tx_hold = 1'b0, tx_abort = 1'b0;
  logic [7:0]  e_tx;
  logic        rv0 = 1'b0, rv1 = 1'b0;
  logic [15:0] ra0 = '0, ra1 = '0;

  logic [7:0]  exp_tx[$];
  logic [23:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  int n_tests = 0, n_fail = 0, we_cnt = 0, re_cnt = 0, tx_cnt = 0;
  int w0, r0, t0;

  uart_bus_master_ctrl #(.READ_LAT(TB_LAT), .BYTE_TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active), .tx_done(tx_done),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_wdata(cpu_wdata),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .cpu_halt(cpu_halt), .host_own(host_own)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    if (a == 16'h0300) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Read data is valid only in the cycle exactly TB_LAT after the bus_re cycle.
  always @(posedge clk) begin
    rv0 <= bus_re;
    ra0 <= bus_addr;
    rv1 <= rv0;
    ra1 <= ra0;
  end
  assign bus_rdata = rv1 ? mem_val(ra1) : 8'h00;
  assign tx_active = tx_busy | tx_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: every host strobe must match a scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_we) begin
        we_cnt++;
        if (exp_wr.size() == 0) check("we_unexp", exp_wr.size(), 1);
        else begin
          logic [23:0] w;
          w = exp_wr.pop_front();
          check("wr_addr", bus_addr, w[23:8]);
          check("wr_data", bus_wdata, w[7:0]);
        end
      end
      if (bus_re) begin
        re_cnt++;
        if (exp_rd.size() == 0) check("re_unexp", exp_rd.size(), 1);
        else check("rd_addr", bus_addr, exp_rd.pop_front());
      end
    end
  end

  // UART TX model.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_cnt++;
        if (exp_tx.size() == 0) begin
          check("tx_unexp", exp_tx.size(), 1);
          e_tx = 8'h00;
        end else begin
          e_tx = exp_tx.pop_front();
          check("tx_data", tx_data, e_tx);
        end
        tx_busy = 1'b1;
        @(negedge clk);
        check("tx_pulse", tx_start, 0);
        repeat (5) @(negedge clk);
        if (!tx_abort) check("tx_hold", tx_data, e_tx);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tx(input int prev);
    for (int i = 0; i < 200 && tx_cnt == prev; i++) @(negedge clk);
    check("tx_seen", tx_cnt, prev + 1);
  endtask

  task automatic do_halt();
    send_byte(8'h00);
    check("halt_rise", cpu_halt, 1);
    check("own_lag", host_own, 0);
    @(negedge clk);
    check("own_rise", host_own, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    cpu_addr = '0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_halt", cpu_halt, 0);
    check("rst_own", host_own, 0);
    check("rst_txs", tx_start, 0);
    check("rst_txd", tx_data, 0);
    #1 cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h99;
    #1 check("pass_we", bus_we, 1);
    check("pass_addr", bus_addr, 16'h1234);
    check("pass_wdata", bus_wdata, 8'h99);
    cpu_we = 1'b0;
    rst = 1'b0;

    do_halt();
    #1 cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 16'h1111;
    #1 check("blk_we", bus_we, 0);
    check("blk_re", bus_re, 0);
    check("blk_addr", bus_addr, 16'h0000);
    cpu_we = 1'b0; cpu_re = 1'b0;

    // Halted write to $2006.
    exp_wr.push_back({16'h2006, 8'h3F});
    w0 = we_cnt;
    send_gap(8'h02); send_gap(8'h20); send_gap(8'h06); send_gap(8'h3F);
    repeat (5) @(negedge clk);
    check("wr_strobes", we_cnt, w0 + 1);

    // Halted read of $0300.
    exp_rd.push_back(16'h0300); exp_tx.push_back(8'h5A);
    r0 = re_cnt; t0 = tx_cnt;
    send_gap(8'h03); send_gap(8'h03); send_gap(8'h00);
    wait_tx(t0);
    check("rd_strobes", re_cnt, r0 + 1);
    repeat (12) @(negedge clk);

    // Read of $2002 while TX is still busy: tx_start must wait.
    tx_hold = 1'b1;
    exp_rd.push_back(16'h2002); exp_tx.push_back(mem_val(16'h2002));
    r0 = re_cnt; t0 = tx_cnt;
    send_gap(8'h03); send_gap(8'h20); send_gap(8'h02);
    repeat (20) @(negedge clk);
    check("tx_held_off", tx_cnt, t0);
    tx_hold = 1'b0;
    wait_tx(t0);
    check("rd2_strobes", re_cnt, r0 + 1);
    repeat (12) @(negedge clk);

    // Resume: bus released first, CPU one cycle later.
    send_byte(8'h01);
    check("res_own", host_own, 0);
    check("res_halt_hold", cpu_halt, 1);
    @(negedge clk);
    check("res_halt", cpu_halt, 0);
    repeat (2) @(negedge clk);

    // Not halted: read reports 0xEE with no strobe, write dropped.
    exp_tx.push_back(8'hEE);
    r0 = re_cnt; t0 = tx_cnt;
    send_gap(8'h03); send_gap(8'h20); send_gap(8'h02);
    wait_tx(t0);
    check("nh_rd_strobes", re_cnt, r0);
    repeat (12) @(negedge clk);
    w0 = we_cnt;
    send_gap(8'h02); send_gap(8'h00); send_gap(8'h10); send_gap(8'h77);
    repeat (5) @(negedge clk);
    check("nh_wr_strobes", we_cnt, w0);
    #1 cpu_re = 1'b1; cpu_addr = 16'hBEEF;
    #1 check("pass_re", bus_re, 1);
    check("pass_re_addr", bus_addr, 16'hBEEF);
    cpu_re = 1'b0;

    // Timeout after a partial write, then a normal read.
    do_halt();
    w0 = we_cnt;
    send_gap(8'h02); send_gap(8'h20);
    repeat (TB_TO + 10) @(negedge clk);
    exp_rd.push_back(16'h2007); exp_tx.push_back(mem_val(16'h2007));
    r0 = re_cnt; t0 = tx_cnt;
    send_gap(8'h03); send_gap(8'h20); send_gap(8'h07);
    wait_tx(t0);
    check("to_rd_strobes", re_cnt, r0 + 1);
    check("to_no_wr", we_cnt, w0);
    repeat (12) @(negedge clk);

    // Reset while in DATA.
    w0 = we_cnt;
    send_gap(8'h02); send_gap(8'h20); send_gap(8'h06);
    rst = 1'b1;
    @(negedge clk);
    check("rd_rst_halt", cpu_halt, 0);
    check("rd_rst_own", host_own, 0);
    check("rd_rst_we", bus_we, 0);
    rst = 1'b0;
    do_halt();
    send_gap(8'h3F);
    repeat (5) @(negedge clk);
    check("rd_rst_no_wr", we_cnt, w0);

    // Reset while in TX_WAIT.
    exp_rd.push_back(16'h2000); exp_tx.push_back(mem_val(16'h2000));
    t0 = tx_cnt;
    send_gap(8'h03); send_gap(8'h20); send_gap(8'h00);
    wait_tx(t0);
    tx_abort = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("tw_rst_txd", tx_data, 0);
    check("tw_rst_txs", tx_start, 0);
    check("tw_rst_halt", cpu_halt, 0);
    check("tw_rst_own", host_own, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    tx_abort = 1'b0;
    do_halt();

    // Status command (0x04).
    t0 = tx_cnt;
`ifdef UART_BUS_STATUS_CMD_EN
    exp_tx.push_back(8'h03);
    send_byte(8'h04);
    repeat (30) @(negedge clk);
    check("status_tx", tx_cnt, t0 + 1);
`else
    send_byte(8'h04);
    repeat (30) @(negedge clk);
    check("status_tx", tx_cnt, t0);
`endif

    check("wr_q_empty", exp_wr.size(), 0);
    check("rd_q_empty", exp_rd.size(), 0);
    check("tx_q_empty", exp_tx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bus_master_ctrl.md
Name: uart_bus_master_ctrl

Overview:
- Host-side debug controller between the UART RX/TX pair and the CPU memory bus of the ppu/mem/vga top level.
- Parses host command bytes and halts/resumes the CPU.
- Sequences single-byte bus writes and reads, including PPU registers $2000–$2007, while the CPU is halted.
- Returns read data over UART TX.
- Muxes bus ownership between the CPU and the host.

Parameters:
- READ_LAT, 1, cycles from bus_re to valid bus_rdata (range 1–4).
- BYTE_TIMEOUT, 2000000, idle cycles between bytes of one command before abort to IDLE.

Ports:
- clk  in  1  system clock (25 MHz domain)
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- tx_start  out  1  one-cycle pulse to start TX
- tx_data  out  8  byte to transmit, held until tx_done
- tx_active  in  1  TX busy
- tx_done  in  1  one-cycle pulse, TX finished
- cpu_addr  in  16  CPU bus address
- cpu_we  in  1  CPU write strobe
- cpu_re  in  1  CPU read strobe
- cpu_wdata  in  8  CPU write data
- bus_addr  out  16  muxed bus address
- bus_we  out  1  muxed write strobe
- bus_re  out  1  muxed read strobe
- bus_wdata  out  8  muxed write data
- bus_rdata  in  8  bus read data
- cpu_halt  out  1  halt request to CPU
- host_own  out  1  host owns bus

Behaviour:
- Reset: FSM=IDLE; cpu_halt=0, host_own=0, tx_start=0, tx_data=0, host bus regs 0; timeout counter 0.
- Commands are the first byte in IDLE:
  - 0x00 halt
  - 0x01 resume
  - 0x02 write: addr_hi, addr_lo, data
  - 0x03 read: addr_hi, addr_lo; 1 byte returned
  - Any other value: ignored, stay IDLE.
- Halt:
  - cpu_halt=1 the cycle after the 0x00 byte.
  - host_own=1 one cycle after cpu_halt rises.
  - Halt while already halted: no change.
- Resume:
  - host_own=0 the cycle after the 0x01 byte.
  - cpu_halt=0 one cycle later.
- Mux:
  - host_own=0: bus_* = cpu_*.
  - host_own=1: bus_* = host registers; cpu_we/cpu_re are blocked.
- FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, BUS_WR, BUS_RD, RD_WAIT, TX_SEND, TX_WAIT.
  - IDLE → ADDR_HI on 0x02/0x03.
  - ADDR_HI → ADDR_LO on byte.
  - ADDR_LO → DATA (write) or BUS_RD (read).
  - DATA → BUS_WR.
- BUS_WR:
  - bus_we high for exactly 1 cycle with addr/data, then → IDLE.
  - Side-effect registers such as $2006/$2007 must see exactly one strobe.
- BUS_RD:
  - bus_re high for exactly 1 cycle.
  - RD_WAIT counts READ_LAT cycles, then latches bus_rdata into tx_data → TX_SEND.
  - $2002/$2007 read side effects occur exactly once per command.
- TX_SEND: waits for tx_active=0, pulses tx_start 1 cycle → TX_WAIT; TX_WAIT → IDLE on tx_done.
- Not halted (host_own=0) at BUS_WR/BUS_RD:
  - No strobe is issued.
  - A write is silently dropped.
  - A read returns 0xEE.
- Byte discard rules:
  - rx_valid in BUS_WR, BUS_RD, RD_WAIT, TX_SEND or TX_WAIT: byte discarded.
  - rx_valid in IDLE with an unknown value: byte discarded.
- Timeout:
  - Counter resets on each rx_valid.
  - In ADDR_HI/ADDR_LO/DATA, reaching BYTE_TIMEOUT-1 → IDLE with no bus op.
- Reset mid-command: immediate return to IDLE; strobes deasserted the same edge; halt released.

Optional Feature:
- Macro: UART_BUS_STATUS_CMD_EN.
- Defined: command 0x04 returns status byte {6'b0, host_own, cpu_halt} via TX_SEND/TX_WAIT.
- Undefined: 0x04 is an unknown command and is ignored; no TX.

Decomposition:
- Package uart_bus_pkg:
  - Command constants CMD_HALT=0x00, CMD_RESUME=0x01, CMD_WRITE=0x02, CMD_READ=0x03, CMD_STATUS=0x04.
  - RD_ERR_BYTE=0xEE.
  - State enum typedef.
- Sub-module bus_owner_mux: purely the host/CPU mux gated by host_own, kept separate for reuse by the future DMA arbiter.

Test Plan:
- Send 0x00 → cpu_halt=1 next cycle, host_own=1 one cycle later; CPU strobes no longer reach bus_we/bus_re.
- Halted; send 0x02,0x20,0x06,0x3F → exactly one bus_we cycle, bus_addr=0x2006, bus_wdata=0x3F.
- Halted; memory model returns 0x5A at 0x0300; send 0x03,0x03,0x00 → one bus_re cycle; after READ_LAT, tx_start pulses with tx_data=0x5A; FSM returns IDLE on tx_done.
- Not halted; send 0x03,0x20,0x02 → no bus_re; TX returns 0xEE. Send 0x02,0x00,0x10,0x77 → no bus_we.
- Send 0x02,0x20 then silence BYTE_TIMEOUT cycles → FSM returns IDLE; a following 0x03,0x20,0x07 read completes normally.
- Assert rst during DATA state, and again during TX_WAIT → outputs return to reset values the next edge; a subsequent 0x00 halt works.
